// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding the field decoder.
//
// Holds the PC, issues word reads to instruction memory, collects the in-order
// responses into a DEPTH-entry FIFO and presents one instruction word plus its
// PC to decode. A redirect flushes buffered words and discards any responses
// still in flight.
//
// Ports:
//   clock, reset                     rising-edge clock, async active-high reset
//   imem_req_valid/addr/ready        word read request channel (addr[1:0]=00)
//   imem_rsp_valid/data              in-order read data, never back-pressured
//   instr_valid/instruction/instr_pc FIFO head toward decode
//   instr_ready                      decode consumes the head this cycle
//   redirect_valid/redirect_pc       control-flow change to a new PC
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_rd, fifo_wr;
  logic [PW-1:0] tag_rd, tag_wr;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   tag_pc    [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check uses registered occupancy only; a same-cycle pop does not
  // free a slot until the next cycle.
  assign occupancy      = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid    = (fifo_count != '0);
  assign instruction    = fifo_data[fifo_rd];
  assign instr_pc       = fifo_pc[fifo_rd];
  assign pop            = instr_valid && instr_ready;

  // A response in the redirect cycle belongs to the old stream.
  assign push           = imem_rsp_valid && (drop == '0) && !redirect_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      inflight   <= '0;
      drop       <= '0;
      fifo_count <= '0;
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      tag_rd     <= '0;
      tag_wr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
        tag_pc[i]    <= '0;
      end
    end else begin
      // Tag queue tracks the PC of every outstanding request, dropped or not.
      if (req_fire) begin
        pc             <= pc + 32'd4;
        tag_pc[tag_wr] <= pc;
        tag_wr         <= ptr_inc(tag_wr);
      end
      if (imem_rsp_valid) begin
        tag_rd <= ptr_inc(tag_rd);
      end
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        drop       <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (imem_rsp_valid && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (push) begin
          fifo_data[fifo_wr] <= imem_rsp_data;
          fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
          fifo_wr            <= ptr_inc(fifo_wr);
        end
        if (pop) begin
          fifo_rd <= ptr_inc(fifo_rd);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  rsp_needs_request: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (inflight != '0));

  drop_within_inflight: assert property (@(posedge clock) disable iff (reset)
    drop <= inflight);

endmodule
